// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares one SDRAM controller Avalon-MM slave port among NUM_MASTERS
//   masters. One transfer in flight at a time, round-robin arbitration with
//   optional fixed priority for master 0. Reads that never return data are
//   terminated after TIMEOUT cycles with zero data and a sticky error flag.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   m_read/m_write      per-master requests
//   m_address/..data/..byteenable  packed per-master command fields
//   m_waitrequest       per-master stall
//   m_readdata          shared read data bus
//   m_readdatavalid     per-master read data strobe
//   s_*                 toward the SDRAM controller s1 port
//   busy                FSM not idle
//   timeout_err         sticky read-timeout flag
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | arbitrate among pending requests, register the grant
// ISSUE     | command of granted master driven onto the slave port
// WAIT_DATA | read accepted, waiting for s_readdatavalid or timeout

module sdram_port_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_W      = 25,
   parameter int DATA_W      = 16,
   parameter int PRIO0       = 1,
   parameter int TIMEOUT     = 1023
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_MASTERS-1:0]        m_read,
   input  logic [NUM_MASTERS-1:0]        m_write,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
   input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_byteenable,
   output logic [NUM_MASTERS-1:0]        m_waitrequest,
   output logic [DATA_W-1:0]             m_readdata,
   output logic [NUM_MASTERS-1:0]        m_readdatavalid,
   output logic [ADDR_W-1:0]             s_address,
   output logic                          s_read,
   output logic                          s_write,
   output logic [DATA_W-1:0]             s_writedata,
   output logic [DATA_W/8-1:0]           s_byteenable,
   input  logic                          s_waitrequest,
   input  logic [DATA_W-1:0]             s_readdata,
   input  logic                          s_readdatavalid,
   output logic                          busy,
   output logic                          timeout_err
);

   localparam int GW   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int BE_W = DATA_W / 8;
   localparam int CW   = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DATA = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [GW-1:0]     g;
   logic [GW-1:0]     rr;
   logic [CW-1:0]     cnt;
   logic [NUM_MASTERS-1:0] req;
   logic [GW-1:0]     rr_pick;
   logic [GW-1:0]     gnt_next;
   logic [GW-1:0]     rr_next;
   logic              cnt_tc;

   logic [ADDR_W-1:0] addr_a  [NUM_MASTERS];
   logic [DATA_W-1:0] wdata_a [NUM_MASTERS];
   logic [BE_W-1:0]   be_a    [NUM_MASTERS];

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
      assign addr_a[i]  = m_address[i*ADDR_W +: ADDR_W];
      assign wdata_a[i] = m_writedata[i*DATA_W +: DATA_W];
      assign be_a[i]    = m_byteenable[i*BE_W +: BE_W];
   end

   assign req    = m_read | m_write;
   assign cnt_tc = (cnt == '0);

   // first requester at or after rr, wrapping
   always_comb begin
      logic [GW-1:0] cand;
      logic          found;
      cand    = '0;
      found   = 1'b0;
      rr_pick = rr;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         cand = GW'((int'(rr) + i) % NUM_MASTERS);
         if (!found && req[cand]) begin
            found   = 1'b1;
            rr_pick = cand;
         end
      end
   end

   assign gnt_next = ((PRIO0 != 0) && req[0]) ? '0 : rr_pick;
   assign rr_next  = (gnt_next == GW'(NUM_MASTERS - 1)) ? '0 : gnt_next + GW'(1);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (|req) state_nxt = ISSUE;
         end
         ISSUE: begin
            // a master withdrawing mid-command is abandoned, nothing issued
            if (!req[g])             state_nxt = IDLE;
            else if (!s_waitrequest) state_nxt = m_read[g] ? WAIT_DATA : IDLE;
         end
         WAIT_DATA: begin
            if (s_readdatavalid || cnt_tc) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // timeout is a down-counter: loaded with TIMEOUT-1 while issuing so the
   // terminal count falls on the TIMEOUT-th cycle after acceptance
   always_ff @(posedge clk) begin
      if (reset) begin
         g           <= '0;
         rr          <= '0;
         cnt         <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == IDLE && (|req)) begin
            g  <= gnt_next;
            rr <= rr_next;
         end
         if (state == ISSUE)
            cnt <= CW'(TIMEOUT - 1);
         else if (state == WAIT_DATA && !cnt_tc)
            cnt <= cnt - CW'(1);
         if (state == WAIT_DATA && !s_readdatavalid && cnt_tc)
            timeout_err <= 1'b1;
      end
   end

   always_comb begin
      s_read          = 1'b0;
      s_write         = 1'b0;
      s_address       = addr_a[g];
      s_writedata     = wdata_a[g];
      s_byteenable    = be_a[g];
      m_waitrequest   = '1;
      m_readdatavalid = '0;
      m_readdata      = s_readdata;
      case (state)
         ISSUE: begin
            s_read           = m_read[g];
            s_write          = m_write[g] & ~m_read[g];
            m_waitrequest[g] = s_waitrequest;
         end
         WAIT_DATA: begin
            if (s_readdatavalid || cnt_tc) m_readdatavalid[g] = 1'b1;
            if (!s_readdatavalid && cnt_tc) m_readdata = '0;
         end
         default: ;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   m_read;
   logic [3:0]   m_write;
   logic [99:0]  m_address;
   logic [63:0]  m_writedata;
   logic [7:0]   m_byteenable;
   logic         s_waitrequest;
   logic [15:0]  s_readdata;
   logic         s_readdatavalid;

   logic [3:0]  a_wait, b_wait, a_rdv, b_rdv;
   logic [15:0] a_rdata, b_rdata, a_swd, b_swd;
   logic [24:0] a_sadr, b_sadr;
   logic        a_srd, b_srd, a_swr, b_swr, a_busy, b_busy, a_terr, b_terr;
   logic [1:0]  a_sbe, b_sbe;

   logic        sel_b;
   logic [3:0]  mon_wait, mon_rdv;
   logic [15:0] mon_rdata, mon_swd;
   logic [24:0] mon_sadr;
   logic        mon_srd, mon_swr, mon_busy, mon_terr;
   logic [1:0]  mon_sbe;

   int n_err = 0;
   int n_checks = 0;
   int lat = 2;
   int rd_left [4];
   int wr_left [4];

   typedef struct {
      bit          wr;
      int          mst;
      logic [24:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
   } acc_t;
   typedef struct {
      int          mst;
      logic [15:0] data;
   } rd_t;
   acc_t exp_acc[$];
   rd_t  exp_rd[$];

   always #10 clk = ~clk;

   sdram_port_arbiter #(.NUM_MASTERS(4), .ADDR_W(25), .DATA_W(16), .PRIO0(1), .TIMEOUT(15)) dut_a (
      .clk(clk), .reset(reset), .m_read(m_read), .m_write(m_write),
      .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
      .m_waitrequest(a_wait), .m_readdata(a_rdata), .m_readdatavalid(a_rdv),
      .s_address(a_sadr), .s_read(a_srd), .s_write(a_swr), .s_writedata(a_swd),
      .s_byteenable(a_sbe), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
      .s_readdatavalid(s_readdatavalid), .busy(a_busy), .timeout_err(a_terr));

   sdram_port_arbiter #(.NUM_MASTERS(4), .ADDR_W(25), .DATA_W(16), .PRIO0(0), .TIMEOUT(15)) dut_b (
      .clk(clk), .reset(reset), .m_read(m_read), .m_write(m_write),
      .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
      .m_waitrequest(b_wait), .m_readdata(b_rdata), .m_readdatavalid(b_rdv),
      .s_address(b_sadr), .s_read(b_srd), .s_write(b_swr), .s_writedata(b_swd),
      .s_byteenable(b_sbe), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
      .s_readdatavalid(s_readdatavalid), .busy(b_busy), .timeout_err(b_terr));

   assign mon_wait  = sel_b ? b_wait  : a_wait;
   assign mon_rdv   = sel_b ? b_rdv   : a_rdv;
   assign mon_rdata = sel_b ? b_rdata : a_rdata;
   assign mon_swd   = sel_b ? b_swd   : a_swd;
   assign mon_sadr  = sel_b ? b_sadr  : a_sadr;
   assign mon_srd   = sel_b ? b_srd   : a_srd;
   assign mon_swr   = sel_b ? b_swr   : a_swr;
   assign mon_busy  = sel_b ? b_busy  : a_busy;
   assign mon_terr  = sel_b ? b_terr  : a_terr;
   assign mon_sbe   = sel_b ? b_sbe   : a_sbe;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int first_zero(input logic [3:0] w);
      for (int i = 0; i < 4; i++) if (!w[i]) return i;
      return -1;
   endfunction

   // slave model: returns {addr[7:0],8'hC3} lat cycles after acceptance; lat=0 never returns
   initial begin
      logic        acc;
      logic [24:0] a;
      int          pending;
      logic [15:0] pdata;
      pending = 0;
      pdata = '0;
      s_readdatavalid = 1'b0;
      s_readdata = 16'h0000;
      forever begin
         @(negedge clk);
         acc = mon_srd && !s_waitrequest;
         a = mon_sadr;
         @(posedge clk);
         #1;
         s_readdatavalid = 1'b0;
         if (acc && lat > 0) begin
            pending = lat;
            pdata = {a[7:0], 8'hC3};
         end
         if (pending > 0) begin
            if (pending == 1) begin
               s_readdatavalid = 1'b1;
               s_readdata = pdata;
            end
            pending--;
         end
      end
   end

   // master agents: hold a request until the given number of transfers is accepted
   initial begin
      m_read = '0;
      m_write = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (m_read[i] && !mon_wait[i] && rd_left[i] > 0) rd_left[i]--;
            else if (m_write[i] && !mon_wait[i] && wr_left[i] > 0) wr_left[i]--;
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            m_read[i]  = (rd_left[i] > 0);
            m_write[i] = (wr_left[i] > 0);
         end
      end
   end

   // scoreboard monitor
   initial begin
      acc_t e;
      rd_t  r;
      forever begin
         @(negedge clk);
         if ((mon_srd || mon_swr) && !s_waitrequest && !reset) begin
            if (exp_acc.size() == 0) begin
               n_checks++; n_err++;
               $display("FAIL acc_unexpected: got addr %0h expected no transfer", mon_sadr);
            end else begin
               e = exp_acc.pop_front();
               chk("acc_master", 32'(first_zero(mon_wait)), 32'(e.mst));
               chk("acc_is_write", 32'(mon_swr), 32'(e.wr));
               chk("acc_addr", 32'(mon_sadr), 32'(e.addr));
               if (e.wr) begin
                  chk("acc_wdata", 32'(mon_swd), 32'(e.data));
                  chk("acc_be", 32'(mon_sbe), 32'(e.be));
               end
            end
         end
         if (mon_rdv != 4'b0000) begin
            if (exp_rd.size() == 0) begin
               n_checks++; n_err++;
               $display("FAIL rdv_unexpected: got strobe %0h expected none", mon_rdv);
            end else begin
               r = exp_rd.pop_front();
               chk("rdv_onehot", 32'(mon_rdv), 32'(1) << r.mst);
               chk("rdv_data", 32'(mon_rdata), 32'(r.data));
            end
         end
      end
   end

   task automatic push_acc(input bit wr, input int mst, input logic [24:0] addr,
                           input logic [15:0] data, input logic [1:0] be);
      acc_t e;
      e.wr = wr; e.mst = mst; e.addr = addr; e.data = data; e.be = be;
      exp_acc.push_back(e);
   endtask

   task automatic push_rd(input int mst, input logic [15:0] data);
      rd_t r;
      r.mst = mst; r.data = data;
      exp_rd.push_back(r);
   endtask

   task automatic wait_done(input string name, input int budget);
      int  n;
      bit  done;
      n = 0;
      done = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
         done = (exp_acc.size() == 0) && (exp_rd.size() == 0) && !mon_busy &&
                (rd_left[0] + rd_left[1] + rd_left[2] + rd_left[3] +
                 wr_left[0] + wr_left[1] + wr_left[2] + wr_left[3] == 0);
      end
      chk(name, 32'(done), 32'd1);
   endtask

   task automatic wait_accept(input string name, output bit ok);
      int n;
      n = 0;
      ok = 0;
      while (!ok && n < 40) begin
         @(negedge clk);
         n++;
         ok = mon_srd && !s_waitrequest;
      end
      chk(name, 32'(ok), 32'd1);
   endtask

   initial begin
      int  nw, nb;
      bit  ok;
      reset = 1'b1;
      s_waitrequest = 1'b0;
      sel_b = 1'b0;
      m_address    = {25'h00000D3, 25'h0001234, 25'h00000B1, 25'h00000A0};
      m_writedata  = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
      m_byteenable = {2'b01, 2'b11, 2'b10, 2'b01};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_read", 32'(a_srd), 32'd0);
      chk("rst_s_write", 32'(a_swr), 32'd0);
      chk("rst_waitreq", 32'(a_wait), 32'hF);
      chk("rst_rdv", 32'(a_rdv), 32'd0);
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_terr", 32'(a_terr), 32'd0);
      chk("rst_s_address", 32'(a_sadr), 32'h00000A0);
      @(posedge clk); #1;
      reset = 1'b0;

      // single write from master 2
      @(negedge clk);
      push_acc(1, 2, 25'h0001234, 16'hBEEF, 2'b11);
      wr_left[2] = 1;
      nw = 0; nb = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (mon_swr) begin
            nw++;
            chk("wr_waitreq", 32'(mon_wait), 32'b1011);
            chk("wr_no_read", 32'(mon_srd), 32'd0);
         end
         if (mon_busy) nb++;
      end
      chk("wr_pulse_cycles", 32'(nw), 32'd1);
      chk("wr_busy_cycles", 32'(nb), 32'd1);
      wait_done("wr_done", 50);

      // fixed priority: master 0 keeps winning until it stops requesting
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         push_acc(0, 0, 25'h00000A0, 16'h0, 2'b0);
         push_rd(0, 16'hA0C3);
      end
      push_acc(0, 1, 25'h00000B1, 16'h0, 2'b0);
      push_rd(1, 16'hB1C3);
      rd_left[0] = 3;
      rd_left[1] = 1;
      wait_done("prio_done", 100);

      // stalled slave on a read from master 3
      @(negedge clk);
      s_waitrequest = 1'b1;
      push_acc(0, 3, 25'h00000D3, 16'h0, 2'b0);
      push_rd(3, 16'hD3C3);
      rd_left[3] = 1;
      ok = 0;
      for (int n = 0; n < 20 && !ok; n++) begin
         @(negedge clk);
         ok = mon_srd;
      end
      chk("stall_read_seen", 32'(ok), 32'd1);
      for (int j = 1; j <= 6; j++) begin
         if (j > 1) @(negedge clk);
         chk("stall_s_read", 32'(mon_srd), 32'd1);
         chk("stall_s_address", 32'(mon_sadr), 32'h00000D3);
         chk("stall_waitreq", 32'(mon_wait), (j == 6) ? 32'b0111 : 32'hF);
         if (j == 5) begin
            @(posedge clk); #1;
            s_waitrequest = 1'b0;
         end
      end
      wait_done("stall_done", 50);

      // read timeout, slave never answers
      @(negedge clk);
      lat = 0;
      chk("to_terr_before", 32'(mon_terr), 32'd0);
      push_acc(0, 1, 25'h00000B1, 16'h0, 2'b0);
      push_rd(1, 16'h0000);
      rd_left[1] = 1;
      wait_accept("to_accept", ok);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k < 15) begin
            chk("to_no_rdv_early", 32'(mon_rdv), 32'd0);
            chk("to_busy", 32'(mon_busy), 32'd1);
         end else if (k == 15) begin
            chk("to_rdv", 32'(mon_rdv), 32'b0010);
            chk("to_data_zero", 32'(mon_rdata), 32'd0);
         end else begin
            chk("to_idle", 32'(mon_busy), 32'd0);
            chk("to_terr_set", 32'(mon_terr), 32'd1);
         end
      end
      repeat (4) @(negedge clk);
      chk("to_terr_sticky", 32'(mon_terr), 32'd1);
      wait_done("to_done", 50);

      // reset during WAIT_DATA, slave data arrives afterwards
      @(negedge clk);
      lat = 3;
      push_acc(0, 2, 25'h0001234, 16'h0, 2'b0);
      rd_left[2] = 1;
      wait_accept("rstmid_accept", ok);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("rstmid_in_wait", 32'(mon_busy), 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk);
         chk("rstmid_rdv", 32'(mon_rdv), 32'd0);
         chk("rstmid_busy", 32'(mon_busy), 32'd0);
         chk("rstmid_s_read", 32'(mon_srd), 32'd0);
         chk("rstmid_waitreq", 32'(mon_wait), 32'hF);
         chk("rstmid_terr", 32'(mon_terr), 32'd0);
      end
      wait_done("rstmid_done", 50);

      // pure round-robin on the PRIO0=0 instance
      @(posedge clk); #1;
      reset = 1'b1;
      lat = 2;
      @(posedge clk); #1;
      reset = 1'b0;
      sel_b = 1'b1;
      @(negedge clk);
      push_acc(0, 0, 25'h00000A0, 16'h0, 2'b0); push_rd(0, 16'hA0C3);
      push_acc(0, 1, 25'h00000B1, 16'h0, 2'b0); push_rd(1, 16'hB1C3);
      push_acc(0, 2, 25'h0001234, 16'h0, 2'b0); push_rd(2, 16'h34C3);
      push_acc(0, 3, 25'h00000D3, 16'h0, 2'b0); push_rd(3, 16'hD3C3);
      push_acc(0, 0, 25'h00000A0, 16'h0, 2'b0); push_rd(0, 16'hA0C3);
      rd_left[0] = 2;
      rd_left[1] = 1;
      rd_left[2] = 1;
      rd_left[3] = 1;
      wait_done("rr_done", 150);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before 500000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single SDRAM controller Avalon-MM slave port among up to N processing-side masters: NIOS data masters, DMA engines and the VGA frame reader. One transfer is in flight at a time. Arbitration is round-robin, with an optional fixed high priority for master 0 (the VGA reader). The block sits in the Qsys system between the requesting masters and the SDRAM controller's s1 port. It runs in the 50 MHz system clock domain that also clocks the controller.

## Interface
Parameters:
- NUM_MASTERS, 4, number of requesters (2..8)
- ADDR_W, 25, word address width toward SDRAM
- DATA_W, 16, data width (multiple of 8)
- PRIO0, 1, 1 = master 0 always wins in IDLE; 0 = pure round-robin
- TIMEOUT, 1023, maximum cycles waited for read data

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- m_read  in  NUM_MASTERS  per-master read request
- m_write  in  NUM_MASTERS  per-master write request
- m_address  in  NUM_MASTERS*ADDR_W  packed; master i at [i*ADDR_W +: ADDR_W]
- m_writedata  in  NUM_MASTERS*DATA_W  packed write data
- m_byteenable  in  NUM_MASTERS*DATA_W/8  packed byte enables
- m_waitrequest  out  NUM_MASTERS  per-master stall
- m_readdata  out  DATA_W  shared read data bus
- m_readdatavalid  out  NUM_MASTERS  per-master read-data strobe
- s_address  out  ADDR_W  to SDRAM controller
- s_read, s_write  out  1  to SDRAM controller
- s_writedata  out  DATA_W; s_byteenable  out  DATA_W/8
- s_waitrequest  in  1; s_readdata  in  DATA_W; s_readdatavalid  in  1
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky; set on read timeout, cleared only by reset

## Operation
- FSM states: IDLE, ISSUE, WAIT_DATA. Registered grant index `g` and round-robin pointer `rr` (both reset to 0).
- Request of master i: `req[i] = m_read[i] | m_write[i]`.
- IDLE:
  - If any req: if PRIO0 and req[0], g<=0; otherwise g<=first i with req[i], searching from rr upward modulo NUM_MASTERS.
  - Next state ISSUE; rr<=g+1 mod NUM_MASTERS.
- ISSUE:
  - s_* are driven combinationally from master g's live inputs.
  - s_read = m_read[g]; s_write = m_write[g] & ~m_read[g]. Read wins if a master asserts both.
  - m_waitrequest[g] = s_waitrequest.
  - When s_waitrequest=0: write -> IDLE; read -> WAIT_DATA, with the timeout counter cleared.
  - If master g drops its request while in ISSUE (an Avalon violation), the FSM returns to IDLE without issuing.
- WAIT_DATA:
  - s_read=s_write=0.
  - On s_readdatavalid: m_readdata=s_readdata and m_readdatavalid[g]=1 in the same cycle (combinational pass-through); next state IDLE.
  - Counter increments each cycle. On reaching TIMEOUT: m_readdatavalid[g]=1 with m_readdata=0, timeout_err<=1, next state IDLE.
- m_waitrequest[i] is 1 for every i other than g in ISSUE, and 1 for all masters in IDLE and WAIT_DATA.
- s_readdatavalid arriving in IDLE or ISSUE is discarded.
- m_readdata equals s_readdata whenever no timeout strobe is active.
- Widths: all packed slices are fixed-width; no arithmetic except rr modulo and the counter (width clog2(TIMEOUT+1)).

## Timing
- Reset values: state IDLE; s_read=0, s_write=0, m_waitrequest all 1, m_readdatavalid all 0, busy=0, timeout_err=0. s_address/s_writedata/s_byteenable = master 0's inputs, don't-care while s_read/s_write are low.
- Arbitration costs 1 cycle. A request seen in IDLE at edge k appears on s_read/s_write in cycle k+1.
- Write, zero-wait slave: IDLE, ISSUE (accepted), IDLE, so 2 cycles per write. Back-to-back requests from different masters therefore issue every 2 cycles.
- Read: 1 cycle arbitration, plus slave accept cycles, plus slave read latency. m_readdatavalid fires in the same cycle as s_readdatavalid.
- Simultaneous requests from all masters in IDLE: exactly one grant per IDLE visit.
- Reset asserted in any state: the next cycle is IDLE with reset values. Slave data in flight at that point is dropped. No partial transfer is re-issued.

## Test plan
- Single write: master 2 writes addr 0x0001234, data 0xBEEF, byteenable 2'b11, slave waitrequest 0. Required: s_write for exactly 1 cycle carrying those values, m_waitrequest[2]=0 in that cycle, busy high for 1 cycle.
- Round-robin, PRIO0=0: masters 0-3 all hold reads; slave latency 2. Required: grant order 0,1,2,3,0. Each master gets m_readdatavalid with the slave data it requested, in that order.
- Priority, PRIO0=1: masters 0 and 1 request continuously. Required: master 0 is granted every IDLE visit and master 1 is never granted. Drop m_read[0] and master 1 is granted at the next IDLE.
- Stalled slave: s_waitrequest held 1 for 5 cycles during a read. Required: s_read and s_address stable for 6 cycles, the read completes, all other m_waitrequest stay 1 throughout.
- Timeout, TIMEOUT=15: slave never returns data. Required: exactly 15 cycles after acceptance, m_readdatavalid[g]=1 with data 0x0000, timeout_err=1 and stays high, FSM back in IDLE.
- Reset mid-read: assert reset during WAIT_DATA, then return s_readdatavalid 2 cycles later. Required: outputs at reset values and no m_readdatavalid pulse.
